// File: rtl/dm_pkg.sv
// Shared definitions for the data-memory front end: default widths,
// memory depth and the DMA sequencer state type.
package dm_pkg;

  localparam int DEF_ADDR_W = 16;
  localparam int DEF_DATA_W = 16;
  localparam int DEF_LEN_W  = 14;   // wide enough to express a full-depth copy
  localparam int DM_DEPTH   = 8192;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2
  } dma_state_t;

endpackage

// File: rtl/dm_dma_arb.sv
// Data-memory port arbiter: the CPU memory stage owns the DM port whenever it
// requests it; otherwise a word-copy DMA engine uses the slot, alternating one
// read cycle and one write cycle per word. Read and write strobes are never
// driven together.
module dm_dma_arb
  import dm_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W,
  parameter int LEN_W  = DEF_LEN_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic              cpu_re,
  input  logic              cpu_we,
  input  logic [DATA_W-1:0] cpu_wrt_data,
  input  logic              dma_start,
  input  logic [ADDR_W-1:0] dma_src,
  input  logic [ADDR_W-1:0] dma_dst,
  input  logic [LEN_W-1:0]  dma_len,
  output logic              dma_busy,
  output logic              dma_done,
  output logic [ADDR_W-1:0] dm_addr,
  output logic              dm_re,
  output logic              dm_we,
  output logic [DATA_W-1:0] dm_wrt_data,
  input  logic [DATA_W-1:0] dm_rd_data
);

  dma_state_t        state;
  logic [ADDR_W-1:0] src_ptr;
  logic [ADDR_W-1:0] dst_ptr;
  logic [LEN_W-1:0]  count;
  logic [DATA_W-1:0] data_buf;

  logic cpu_req;
  logic dma_gnt;

  assign cpu_req = cpu_re | cpu_we;
  assign dma_gnt = ~cpu_req;

  // Port mux: CPU passes straight through; otherwise the DMA state drives the port.
  always_comb begin
    // NOTE: every output gets a default first, so no path through this block can infer a latch.
    dm_addr     = '0;
    dm_re       = 1'b0;
    dm_we       = 1'b0;
    dm_wrt_data = '0;
    if (cpu_req) begin
      dm_addr     = cpu_addr;
      dm_wrt_data = cpu_wrt_data;
      // A simultaneous read+write request is malformed: suppress both strobes.
      dm_re       = cpu_re & ~cpu_we;
      dm_we       = cpu_we & ~cpu_re;
    end else begin
      case (state)
        RD: begin
          dm_addr = src_ptr;
          dm_re   = 1'b1;
        end
        WR: begin
          dm_addr     = dst_ptr;
          dm_we       = 1'b1;
          dm_wrt_data = data_buf;
        end
        default: ;
      endcase
    end
  end

  // DMA sequencer, command registers, read buffer and status outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state    <= IDLE;
      src_ptr  <= '0;
      dst_ptr  <= '0;
      count    <= '0;
      data_buf <= '0;
      dma_busy <= 1'b0;
      dma_done <= 1'b0;
    end else begin
      dma_done <= 1'b0;
      case (state)
        IDLE: begin
          // Starts are only looked at here, so a start while busy is ignored.
          if (dma_start) begin
            if (dma_len != '0) begin
              src_ptr  <= dma_src;
              dst_ptr  <= dma_dst;
              count    <= dma_len;
              dma_busy <= 1'b1;
              state    <= RD;
            end else begin
              dma_done <= 1'b1;
            end
          end
        end
        RD: begin
          // Capture only when this cycle's read was ours, never a CPU read.
          if (dma_gnt) begin
            data_buf <= dm_rd_data;
            state    <= WR;
          end
        end
        WR: begin
          if (dma_gnt) begin
            src_ptr <= src_ptr + 1'b1;
            dst_ptr <= dst_ptr + 1'b1;
            count   <= count - 1'b1;
            if (count == LEN_W'(1)) begin
              dma_busy <= 1'b0;
              dma_done <= 1'b1;
              state    <= IDLE;
            end else begin
              state <= RD;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
